// File: rtl/alien_fire_ctrl_if.sv
// Shot handshake between the alien fire scheduler and the alien bullet.
// Scheduler drives the request and muzzle coordinates; bullet answers with
// bullet_active while its shot is in flight.
interface alien_fire_ctrl_if;
  logic        fire;
  logic [11:0] alien_x;
  logic [11:0] alien_y;
  logic        bullet_active;

  modport master (output fire, output alien_x, output alien_y, input bullet_active);
  modport slave  (input fire, input alien_x, input alien_y, output bullet_active);
endinterface

// File: rtl/alien_fire_ctrl.sv
// Purpose: after a frame-counted cooldown, pick a pseudo-random column and fire from its lowest live alien.
// Latency: SCAN entered 1 cycle after cooldown expiry; fire rises 1..ALIEN_COLS cycles after SCAN entry.
// Backpressure: fire is held as a level until bullet_active is seen; cooldown waits while bullet_active is high.
module alien_fire_ctrl #(
  parameter int          ALIEN_ROWS      = 4,
  parameter int          ALIEN_COLS      = 8,
  parameter int          ALIEN_W         = 32,
  parameter int          ALIEN_H         = 24,
  parameter int          SPACING_X       = 48,
  parameter int          SPACING_Y       = 36,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                             pixel_clk,
  input  logic                             rst,
  input  logic                             fsync,
  input  logic                             enable,
  input  logic [ALIEN_ROWS*ALIEN_COLS-1:0] alive,
  input  logic [11:0]                      fleet_x,
  input  logic [11:0]                      fleet_y,
  alien_fire_ctrl_if.master                shot
);

  localparam int          CW        = $clog2(ALIEN_COLS);
  localparam int          RW        = (ALIEN_ROWS > 1) ? $clog2(ALIEN_ROWS) : 1;
  localparam logic [7:0]  CD_RELOAD = 8'(COOLDOWN_FRAMES);
  localparam logic [CW:0] LAST_SCAN = (CW+1)'(ALIEN_COLS - 1);
  localparam logic [11:0] X_OFS     = 12'(ALIEN_W / 2);
  localparam logic [11:0] Y_OFS     = 12'(ALIEN_H);
  localparam logic [11:0] PITCH_X   = 12'(SPACING_X);
  localparam logic [11:0] PITCH_Y   = 12'(SPACING_Y);

  typedef enum logic [1:0] {COOLDOWN, SCAN, ARMED} state_t;

  state_t          state, state_nxt;
  logic [15:0]     lfsr;
  logic [7:0]      cd_cnt, cd_cnt_nxt;
  logic [CW-1:0]   start_col, start_col_nxt, cur_col;
  logic [CW:0]     scan_cnt, scan_cnt_nxt;
  logic [11:0]     x_q, x_nxt, y_q, y_nxt;
  logic            col_hit;
  logic [RW-1:0]   hit_row;
  logic [ALIEN_COLS-1:0] row_bits;

  // Free-running Fibonacci LFSR (taps 16,14,13,11); a nonzero seed keeps it out of the all-zero lockup
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Column wraps naturally because ALIEN_COLS is a power of two
  assign cur_col = start_col + scan_cnt[CW-1:0];

  // Find the lowest live alien (highest row index) in the column under test
  always_comb begin
    col_hit  = 1'b0;
    hit_row  = '0;
    row_bits = '0;
    for (int r = 0; r < ALIEN_ROWS; r++) begin
      row_bits = alive[r*ALIEN_COLS +: ALIEN_COLS];
      if (row_bits[cur_col]) begin
        col_hit = 1'b1;
        hit_row = RW'(r);
      end
    end
  end

  // Next state, cooldown counter, scan pointer and shot coordinates
  always_comb begin
    state_nxt     = state;
    cd_cnt_nxt    = cd_cnt;
    start_col_nxt = start_col;
    scan_cnt_nxt  = scan_cnt;
    x_nxt         = x_q;
    y_nxt         = y_q;
    if (!enable) begin
      state_nxt  = COOLDOWN;
      cd_cnt_nxt = CD_RELOAD;
    end else begin
      case (state)
        COOLDOWN: begin
          if (cd_cnt == 8'd0) begin
            // Counter parks at zero while a previous shot is still flying
            if (!shot.bullet_active) begin
              state_nxt     = SCAN;
              start_col_nxt = lfsr[CW-1:0];
              scan_cnt_nxt  = '0;
            end
          end else if (fsync) begin
            cd_cnt_nxt = cd_cnt - 8'd1;
          end
        end
        SCAN: begin
          if (col_hit) begin
            // alive/fleet are sampled only here; coordinates then stay frozen in ARMED
            x_nxt     = fleet_x + 12'(cur_col) * PITCH_X + X_OFS;
            y_nxt     = fleet_y + 12'(hit_row) * PITCH_Y + Y_OFS;
            state_nxt = ARMED;
          end else if (scan_cnt == LAST_SCAN) begin
            state_nxt  = COOLDOWN;
            cd_cnt_nxt = CD_RELOAD;
          end else begin
            scan_cnt_nxt = scan_cnt + (CW+1)'(1);
          end
        end
        ARMED: begin
          if (shot.bullet_active) begin
            state_nxt  = COOLDOWN;
            cd_cnt_nxt = CD_RELOAD;
          end
        end
        default: begin
          state_nxt  = COOLDOWN;
          cd_cnt_nxt = CD_RELOAD;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= COOLDOWN;
      cd_cnt    <= CD_RELOAD;
      start_col <= '0;
      scan_cnt  <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state     <= state_nxt;
      cd_cnt    <= cd_cnt_nxt;
      start_col <= start_col_nxt;
      scan_cnt  <= scan_cnt_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
    end
  end

  // fire comes straight off the state register so an async reset drops it at once
  assign shot.fire    = (state == ARMED);
  assign shot.alien_x = x_q;
  assign shot.alien_y = y_q;

endmodule

// File: tb/tb_alien_fire_ctrl.sv
// Bench for alien_fire_ctrl: directed sequence with randomized formations,
// a behavioural target-selection model and a shadow LFSR for the start column.
module tb_alien_fire_ctrl;

  logic        pixel_clk = 1'b0;
  logic        rst       = 1'b1;
  logic        fsync     = 1'b0;
  logic        enable    = 1'b0;
  logic [31:0] alive     = '0;
  logic [11:0] fleet_x   = '0;
  logic [11:0] fleet_y   = '0;

  alien_fire_ctrl_if shot_if ();

  alien_fire_ctrl dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .fsync     (fsync),
    .enable    (enable),
    .alive     (alive),
    .fleet_x   (fleet_x),
    .fleet_y   (fleet_y),
    .shot      (shot_if.master)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Shadow LFSR: x^16+x^14+x^13+x^11, shifting left, advancing every edge out of reset
  logic [15:0] m_lfsr = 16'hACE1;
  always @(posedge pixel_clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  logic [11:0] ex, ey;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // n fsync pulses spaced 3 cycles apart; returns just after the edge sampling the last one
  task automatic pulse_fsyncs(input int n);
    for (int i = 0; i < n; i++) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      if (i != n - 1) begin
        tick();
        tick();
      end
    end
  endtask

  // Walk columns from start, wrapping; the lowest live alien is the largest row index
  function automatic bit model_target(input logic [2:0] start, input logic [31:0] alv,
                                      output int k, output int col, output int row);
    for (int s = 0; s < 8; s++) begin
      int c;
      c = (int'(start) + s) % 8;
      for (int r = 3; r >= 0; r--) begin
        if (alv[r*8 + c]) begin
          k = s; col = c; row = r;
          return 1'b1;
        end
      end
    end
    k = 0; col = 0; row = 0;
    return 1'b0;
  endfunction

  // Call just after the edge on which the cooldown condition became qualifying
  task automatic expect_shot(input string tag, output bit found);
    int k, col, row;
    found = model_target(m_lfsr[2:0], alive, k, col, row);
    if (found) begin
      repeat (k + 1) tick();
      chk({tag, "_pre"}, 32'(shot_if.fire), 32'd0);
      tick();
      ex = 12'((int'(fleet_x) + col * 48 + 16) % 4096);
      ey = 12'((int'(fleet_y) + row * 36 + 24) % 4096);
      chk({tag, "_fire"}, 32'(shot_if.fire), 32'd1);
      chk({tag, "_x"}, 32'(shot_if.alien_x), 32'(ex));
      chk({tag, "_y"}, 32'(shot_if.alien_y), 32'(ey));
    end else begin
      repeat (10) tick();
      chk({tag, "_nofire"}, 32'(shot_if.fire), 32'd0);
    end
  endtask

  // Bullet side: fire held with frozen coords, fsync seen, bullet goes active, fire drops
  task automatic launch(input string tag);
    for (int i = 0; i < 3; i++) begin
      fleet_x = 12'($urandom);
      fleet_y = 12'($urandom);
      alive   = $urandom;
      tick();
      chk({tag, "_hold"}, 32'(shot_if.fire), 32'd1);
      chk({tag, "_hold_x"}, 32'(shot_if.alien_x), 32'(ex));
      chk({tag, "_hold_y"}, 32'(shot_if.alien_y), 32'(ey));
    end
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
    chk({tag, "_pre_launch"}, 32'(shot_if.fire), 32'd1);
    shot_if.bullet_active = 1'b1;
    tick();
    chk({tag, "_drop"}, 32'(shot_if.fire), 32'd0);
    tick();
    tick();
    shot_if.bullet_active = 1'b0;
  endtask

  task automatic full_shot(input string tag);
    bit found;
    pulse_fsyncs(59);
    repeat (3) tick();
    chk({tag, "_cd59"}, 32'(shot_if.fire), 32'd0);
    pulse_fsyncs(1);
    expect_shot(tag, found);
    if (found) launch(tag);
  endtask

  initial begin
    bit found;
    shot_if.bullet_active = 1'b0;

    // Reset held from time zero, observed between edges
    #12;
    chk("rst_fire", 32'(shot_if.fire), 32'd0);
    chk("rst_x", 32'(shot_if.alien_x), 32'd0);
    chk("rst_y", 32'(shot_if.alien_y), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // Every alien alive: first shot only after exactly 60 fsyncs
    alive   = 32'hFFFF_FFFF;
    fleet_x = 12'($urandom);
    fleet_y = 12'($urandom);
    full_shot("full");

    // Only column 5 alive, rows 0 and 2
    alive   = 32'h0020_0020;
    fleet_x = 12'd100;
    fleet_y = 12'd50;
    pulse_fsyncs(59);
    repeat (3) tick();
    chk("col5_cd59", 32'(shot_if.fire), 32'd0);
    pulse_fsyncs(1);
    expect_shot("col5", found);
    chk("col5_x_abs", 32'(shot_if.alien_x), 32'd356);
    chk("col5_y_abs", 32'(shot_if.alien_y), 32'd146);
    for (int i = 0; i < 3; i++) begin
      fleet_x = fleet_x + 12'd7;
      tick();
      chk("col5_fleet_move_x", 32'(shot_if.alien_x), 32'd356);
    end

    // enable dropped while armed
    enable = 1'b0;
    tick();
    chk("en_drop_fire", 32'(shot_if.fire), 32'd0);
    enable = 1'b1;
    fleet_x = 12'd100;
    alive   = 32'h0020_0020;
    pulse_fsyncs(59);
    repeat (3) tick();
    chk("en_reload_cd59", 32'(shot_if.fire), 32'd0);
    pulse_fsyncs(1);
    expect_shot("after_en", found);

    // Asynchronous reset while armed
    #3 rst = 1'b1;
    #1;
    chk("rst_armed_fire", 32'(shot_if.fire), 32'd0);
    chk("rst_armed_x", 32'(shot_if.alien_x), 32'd0);
    chk("rst_armed_y", 32'(shot_if.alien_y), 32'd0);
    #3 rst = 1'b0;
    tick();

    // Empty formation: no fire, counter reloads for a full new cooldown
    alive = '0;
    fleet_x = 12'($urandom);
    fleet_y = 12'($urandom);
    pulse_fsyncs(60);
    expect_shot("empty", found);
    alive = $urandom | 32'h1;
    full_shot("after_empty");

    // Bullet still in flight when the cooldown expires
    shot_if.bullet_active = 1'b1;
    alive = $urandom & $urandom | 32'h8000_0000;
    pulse_fsyncs(60);
    repeat (20) tick();
    chk("bullet_hold", 32'(shot_if.fire), 32'd0);
    shot_if.bullet_active = 1'b0;
    expect_shot("bullet_fall", found);
    if (found) launch("bullet_fall");

    // Randomized formations including sparse ones and coordinate wrap
    for (int it = 0; it < 6; it++) begin
      alive   = (it % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom);
      fleet_x = 12'($urandom_range(3800, 4095));
      fleet_y = 12'($urandom_range(3900, 4095));
      pulse_fsyncs(60);
      expect_shot("rand", found);
      if (found) launch("rand");
    end

    // Asynchronous reset during SCAN
    alive = 32'h0100_0000;
    fleet_x = 12'd500;
    fleet_y = 12'd20;
    pulse_fsyncs(60);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_scan_fire", 32'(shot_if.fire), 32'd0);
    chk("rst_scan_x", 32'(shot_if.alien_x), 32'd0);
    chk("rst_scan_y", 32'(shot_if.alien_y), 32'd0);
    #3 rst = 1'b0;
    tick();
    alive = 32'hFFFF_FFFF;
    full_shot("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alien_fire_ctrl.md
# alien_fire_ctrl

Alien-side shot scheduler: after a frame-counted cooldown, picks a pseudo-random column of the alien formation and selects the lowest live alien in it. It then presents a fire request with that alien's muzzle coordinates and holds it until the alien bullet reports launch. It sits between the alien group state (alive mask, formation origin) and the alien bullet block, driving that block's `fire`/`alien_x`/`alien_y` inputs and consuming its `bullet_active`.

## Interface
Parameters:
- `ALIEN_ROWS`, 4: formation rows, 1..8.
- `ALIEN_COLS`, 8: formation columns; power of two, 2..16.
- `ALIEN_W`, 32: alien sprite width, pixels.
- `ALIEN_H`, 24: alien sprite height, pixels.
- `SPACING_X`, 48: column pitch, pixels.
- `SPACING_Y`, 36: row pitch, pixels.
- `COOLDOWN_FRAMES`, 60: fsync pulses between shots, 1..255.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; nonzero.

Ports:
- `pixel_clk`, input, 1: only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `fsync`, input, 1: one-cycle frame-start pulse.
- `enable`, input, 1: game running; low aborts and holds the block idle.
- `alive`, input, ALIEN_ROWS*ALIEN_COLS: bit `row*ALIEN_COLS+col` = alien alive.
- `fleet_x`, input, 12: formation origin x (left of column 0).
- `fleet_y`, input, 12: formation origin y (top of row 0).
- `bullet_active`, input, 1: from alien bullet; high while a shot is in flight.
- `fire`, output, 1: shot request, level.
- `alien_x`, output, 12: shot x, stable whenever `fire`=1.
- `alien_y`, output, 12: shot y, stable whenever `fire`=1.

## Operation
- 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every `pixel_clk` cycle, including during reset release. It never loads zero.
- Cooldown counter (8-bit): reloaded to COOLDOWN_FRAMES on reset, on `enable`=0, and on leaving ARMED. It decrements by 1 on each `fsync` cycle while nonzero in COOLDOWN.
- State machine:
  - COOLDOWN: `fire`=0. When counter==0, `enable`=1 and `bullet_active`=0, go to SCAN. While `bullet_active`=1 the block waits with the counter held at 0.
  - SCAN: on entry, latch start column = `lfsr[log2(ALIEN_COLS)-1:0]` and scan count = 0. Each cycle, test the current column (start+count mod ALIEN_COLS):
    - If any alive bit in that column is set, take the highest set row index as the row. Register `alien_x` = fleet_x + col*SPACING_X + ALIEN_W/2 and `alien_y` = fleet_y + row*SPACING_Y + ALIEN_H, then go to ARMED.
    - Otherwise increment the count. After ALIEN_COLS empty columns, reload the counter and return to COOLDOWN with no fire.
  - ARMED: `fire`=1 and the coordinates are held. When `bullet_active`=1 is seen, go to COOLDOWN and reload the counter.
- `enable`=0 in any state forces COOLDOWN next cycle, with `fire`=0 and the counter reloaded.
- Arithmetic: all coordinate math is unsigned 12-bit with modulo-4096 wrap; no saturation. `alive` and `fleet_*` are sampled on the hit cycle only, and later changes do not alter held coordinates.

## Timing
- Reset values: `fire`=0, `alien_x`=0, `alien_y`=0, state COOLDOWN, counter=COOLDOWN_FRAMES, lfsr=LFSR_SEED.
- COOLDOWN to SCAN: 1 cycle after the qualifying condition.
- SCAN latency: 1..ALIEN_COLS cycles. `fire` and the coordinates update together on the clock edge after the hit cycle.
- Handshake: the bullet samples `fire` at its next `fsync`, and `bullet_active` rises 1 cycle later. `fire` drops the cycle after `bullet_active` is seen. One cycle of overlap is legal, because the bullet ignores `fire` while active.
- `fsync` during SCAN or ARMED does not touch the counter.
- Asynchronous `rst` mid-ARMED drops `fire` immediately, with no clock needed.

## Test plan
- Reset with `rst` pulsed asynchronously between edges -> `fire`=0 and coords=0 immediately; with the column set full, the first `fire` occurs only after exactly 60 `fsync` pulses.
- Only column 5 alive, at rows 0 and 2; fleet=(100,50); defaults -> `fire`=1 with `alien_x`=356 and `alien_y`=146. Coords stay unchanged while `fleet_x` moves during ARMED.
- `alive`=0 -> no `fire`; after 8 scan cycles the counter reloads and the next attempt starts 60 fsyncs later.
- `bullet_active` held high when the counter reaches 0 -> `fire` stays 0. `fire` rises at most ALIEN_COLS+1 cycles after `bullet_active` falls.
- Handshake loop with a bullet model -> `fire` holds across cycles until `bullet_active` rises, drops 1 cycle after, and the counter restarts at 60.
- `enable` dropped in ARMED -> `fire`=0 the next cycle and the counter is reloaded. `rst` asserted in SCAN -> immediate reset values.
